// File: rtl/jpeg_ac_rle_encoder.sv
// ---------------------------------------------------------------------------
// jpeg_ac_rle_encoder
//
// Zero-run-length and magnitude-category encoder for one 8x8 block of
// quantized coefficients. The 64 coefficients arrive in zigzag order. The
// encoder emits one token for the DC term, one for each nonzero AC term, one
// for each ZRL (run of sixteen zeros) and one EOB when the block ends in zeros.
//
// Handshake (both sides): a word moves on a cycle where valid && ready.
// The producer holds its word stable until it moves. out_* is a register that
// keeps its value while out_valid && !out_ready. in_ready does not depend on
// in_valid.
//
// Optional feature, macro JPEG_RLE_DC_DIFF_EN:
//   defined   - the DC token codes coef - pred, and pred then takes the new
//               DC. rst or blk_restart clears pred.
//   undefined - the DC token codes the raw coefficient. blk_restart is ignored.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      coefficient valid
//   in_ready      encoder accepts a coefficient this cycle
//   in_coef       signed quantized coefficient (DW bits)
//   blk_restart   clears the DC predictor (feature builds only)
//   out_valid     token valid
//   out_ready     downstream accepts the token
//   out_run       zero run in front of the value (15 for ZRL, 0 for EOB/DC)
//   out_size      magnitude category 0..DW (0 for ZRL/EOB)
//   out_amp       amplitude bits, LSB-aligned; upper bits are zero
//   out_dc        token is the DC term
//   out_last      final token of the block
//   dbg_state     current FSM state (0 ACCEPT, 1 ZRL, 2 VAL)
// ---------------------------------------------------------------------------
module jpeg_ac_rle_encoder #(
    parameter int DW = 12,
    parameter int RW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_coef,
    input  logic                 blk_restart,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        out_run,
    output logic [3:0]           out_size,
    output logic [DW:0]          out_amp,
    output logic                 out_dc,
    output logic                 out_last,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ZRL    = 2'd1,
        ST_VAL    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [5:0]           idx_q;
    logic [5:0]           zero_run_q;
    logic [1:0]           zrl_cnt_q;     // ZRLs left, counting the one in the output register
    logic signed [DW:0]   pend_val_q;    // value held back behind its ZRLs
    logic [RW-1:0]        pend_run_q;
    logic                 pend_last_q;

    logic                 out_free;
    logic                 accept;
    logic signed [DW-1:0] coef_sat;
    logic                 coef_zero;
    logic signed [DW:0]   ac_val;
    logic signed [DW:0]   dc_val;

    // Token to load into the output register this cycle
    logic                 tok_load;
    logic [RW-1:0]        tok_run;
    logic signed [DW:0]   tok_val;
    logic                 tok_is_value;
    logic                 tok_dc;
    logic                 tok_last;
    logic [3:0]           tok_size;
    logic [DW:0]          tok_amp;
    logic                 long_run;

    // Number of significant bits in |v|; 0 when v is zero.
    function automatic logic [3:0] cat_of(input logic signed [DW:0] v);
        logic [DW:0] mag;
        logic [3:0]  c;
        mag = v[DW] ? $unsigned(-v) : $unsigned(v);
        c   = 4'd0;
        for (int i = 0; i <= DW; i++) begin
            if (mag[i]) c = 4'(i + 1);
        end
        return c;
    endfunction

    // A negative value is coded as (v - 1) cut down to sz bits, which is the
    // one's complement of |v|.
    function automatic logic [DW:0] amp_of(input logic signed [DW:0] v,
                                           input logic [3:0]         sz);
        logic [DW:0] mask;
        logic [DW:0] raw;
        mask = ((DW+1)'(1) << sz) - (DW+1)'(1);
        raw  = v[DW] ? $unsigned(v - (DW+1)'(1)) : $unsigned(v);
        return raw & mask;
    endfunction

    // The most negative code has no positive twin, so it is pulled in by one.
    assign coef_sat  = (in_coef == {1'b1, {(DW-1){1'b0}}})
                     ? {1'b1, {(DW-2){1'b0}}, 1'b1} : in_coef;
    assign coef_zero = (coef_sat == '0);
    assign ac_val    = {coef_sat[DW-1], coef_sat};

`ifdef JPEG_RLE_DC_DIFF_EN
    logic signed [DW-1:0] pred_q;
    logic signed [DW-1:0] pred_eff;

    // A restart on the same cycle as the DC clears the predictor before the
    // difference is formed.
    assign pred_eff = blk_restart ? '0 : pred_q;
    assign dc_val   = ac_val - {pred_eff[DW-1], pred_eff};

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q <= '0;
        end else if (accept && (idx_q == 6'd0)) begin
            pred_q <= coef_sat;
        end else if (blk_restart) begin
            pred_q <= '0;
        end
    end
`else
    logic unused_blk_restart;

    assign unused_blk_restart = blk_restart;
    assign dc_val             = ac_val;
`endif

    assign out_free  = !out_valid || out_ready;
    assign in_ready  = !rst && (state_q == ST_ACCEPT) && out_free;
    assign accept    = in_valid && in_ready;
    assign dbg_state = state_q;

    // Next state and the token to load
    always_comb begin
        state_d      = state_q;
        tok_load     = 1'b0;
        tok_run      = '0;
        tok_val      = '0;
        tok_is_value = 1'b0;
        tok_dc       = 1'b0;
        tok_last     = 1'b0;
        long_run     = 1'b0;
        unique case (state_q)
            ST_ACCEPT: begin
                if (accept) begin
                    if (idx_q == 6'd0) begin
                        tok_load     = 1'b1;
                        tok_val      = dc_val;
                        tok_is_value = 1'b1;
                        tok_dc       = 1'b1;
                    end else if (coef_zero) begin
                        // A trailing run is never coded; the block ends in an EOB.
                        if (idx_q == 6'd63) begin
                            tok_load = 1'b1;
                            tok_last = 1'b1;
                        end
                    end else if (zero_run_q >= 6'd16) begin
                        // Send the first ZRL now and hold the value back.
                        long_run = 1'b1;
                        tok_load = 1'b1;
                        tok_run  = '1;
                        state_d  = ST_ZRL;
                    end else begin
                        tok_load     = 1'b1;
                        tok_run      = zero_run_q[RW-1:0];
                        tok_val      = ac_val;
                        tok_is_value = 1'b1;
                        tok_last     = (idx_q == 6'd63);
                    end
                end
            end
            ST_ZRL: begin
                // A ZRL always sits in the output register here, so out_ready
                // means it moves this cycle.
                if (out_ready) begin
                    if (zrl_cnt_q > 2'd1) begin
                        tok_load = 1'b1;
                        tok_run  = '1;
                    end else begin
                        state_d = ST_VAL;
                    end
                end
            end
            ST_VAL: begin
                if (out_free) begin
                    tok_load     = 1'b1;
                    tok_run      = pend_run_q;
                    tok_val      = pend_val_q;
                    tok_is_value = 1'b1;
                    tok_last     = pend_last_q;
                    state_d      = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    assign tok_size = tok_is_value ? cat_of(tok_val) : 4'd0;
    assign tok_amp  = tok_is_value ? amp_of(tok_val, tok_size) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // Block position, zero run and the value held back behind its ZRLs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            zero_run_q  <= '0;
            zrl_cnt_q   <= '0;
            pend_val_q  <= '0;
            pend_run_q  <= '0;
            pend_last_q <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= idx_q + 6'd1;
                if ((idx_q == 6'd0) || (idx_q == 6'd63) || !coef_zero) begin
                    zero_run_q <= '0;
                end else begin
                    zero_run_q <= zero_run_q + 6'd1;
                end
                if (long_run) begin
                    zrl_cnt_q   <= zero_run_q[5:4];
                    pend_val_q  <= ac_val;
                    pend_run_q  <= zero_run_q[RW-1:0];
                    pend_last_q <= (idx_q == 6'd63);
                end
            end
            if ((state_q == ST_ZRL) && out_ready && (zrl_cnt_q > 2'd1)) begin
                zrl_cnt_q <= zrl_cnt_q - 2'd1;
            end
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_run   <= '0;
            out_size  <= '0;
            out_amp   <= '0;
            out_dc    <= 1'b0;
            out_last  <= 1'b0;
        end else if (tok_load) begin
            out_valid <= 1'b1;
            out_run   <= tok_run;
            out_size  <= tok_size;
            out_amp   <= tok_amp;
            out_dc    <= tok_dc;
            out_last  <= tok_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jpeg_ac_rle_encoder.sv
// ---------------------------------------------------------------------------
// tb_jpeg_ac_rle_encoder
//
// Directed bench for jpeg_ac_rle_encoder. Blocks are sent in zigzag order.
// Each step pushes its hand-worked tokens onto exp_q. A monitor on the falling
// edge takes each transferred token off exp_q and compares the two. It also
// checks that the output fields stay stable while stalled and that in_ready
// is low while a ZRL is showing.
// ---------------------------------------------------------------------------
module tb_jpeg_ac_rle_encoder;

    localparam int DW = 12;
    localparam int RW = 4;
    localparam int W  = RW + 4 + (DW + 1) + 2;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_coef;
    logic                 blk_restart;
    logic                 out_valid;
    logic                 out_ready;
    logic [RW-1:0]        out_run;
    logic [3:0]           out_size;
    logic [DW:0]          out_amp;
    logic                 out_dc;
    logic                 out_last;
    logic [1:0]           dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_assert;
    int           n_fail;
    bit           stall_en;
    int           blk[64];

    logic [W-1:0] held_tok;
    logic         held_v;
    logic [W-1:0] exp_tok_v;
    logic [W-1:0] cur_tok;

    jpeg_ac_rle_encoder #(.DW(DW), .RW(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_coef     (in_coef),
        .blk_restart (blk_restart),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_run     (out_run),
        .out_size    (out_size),
        .out_amp     (out_amp),
        .out_dc      (out_dc),
        .out_last    (out_last),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Downstream readiness: always ready, or a coin toss per cycle when stalling
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    assign cur_tok = {out_run, out_size, out_amp, out_dc, out_last};

    function automatic logic [W-1:0] tok(input int run, input int size, input int amp,
                                          input bit dc, input bit last);
        return {RW'(run), 4'(size), (DW+1)'(amp), dc, last};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    initial held_v = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                n_assert++;
                assert (out_valid === 1'b1 && cur_tok === held_tok) else begin
                    n_fail++;
                    $error("FAIL stall_hold: got valid=%b tok=%h, required valid=1 tok=%h",
                           out_valid, cur_tok, held_tok);
                end
            end
            if (out_valid === 1'b1 && out_run === 4'hF && out_size === 4'd0) begin
                n_assert++;
                assert (in_ready === 1'b0) else begin
                    n_fail++;
                    $error("FAIL zrl_in_ready: got %b, required 0", in_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_token: got tok=%h, required none", cur_tok);
                end
                if (exp_q.size() != 0) begin
                    exp_tok_v = exp_q.pop_front();
                    n_assert++;
                    assert (cur_tok === exp_tok_v) else begin
                        n_fail++;
                        $error("FAIL token: got run=%0d size=%0d amp=%h dc=%b last=%b (%h), required %h",
                               out_run, out_size, out_amp, out_dc, out_last, cur_tok, exp_tok_v);
                    end
                end
            end
            held_v   = out_valid && !out_ready;
            held_tok = cur_tok;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic exp_tok(input int run, input int size, input int amp,
                           input bit dc, input bit last);
        exp_q.push_back(tok(run, size, amp, dc, last));
    endtask

    task automatic send(input int v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_coef  = DW'(v);
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_assert++;
        assert (in_ready === 1'b1) else begin
            n_fail++;
            $error("FAIL send_timeout: in_ready got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        blk_restart = 1'b0;
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 0;
    endtask

    task automatic send_block(input bit restart);
        for (int i = 0; i < 64; i++) begin
            blk_restart = restart && (i == 0);
            send(blk[i]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: %0d tokens outstanding, required 0", exp_q.size());
        end
        n_assert++;
        assert (out_valid === 1'b0 && dbg_state === 2'd0) else begin
            n_fail++;
            $error("FAIL idle: got valid=%b state=%0d, required 0/0", out_valid, dbg_state);
        end
    endtask

    // Blocks reused by the no-stall and stall runs
    task automatic load_p2();
        clear_blk();
        blk[1] = -3; blk[63] = 1;
        exp_tok(0, 0, 0, 1, 0);
        exp_tok(0, 2, 0, 0, 0);
        exp_tok(15, 0, 0, 0, 0); exp_tok(15, 0, 0, 0, 0); exp_tok(15, 0, 0, 0, 0);
        exp_tok(13, 1, 1, 0, 1);
    endtask

    task automatic load_p3();
        clear_blk();
        blk[21] = 7;
        exp_tok(0, 0, 0, 1, 0);
        exp_tok(15, 0, 0, 0, 0);
        exp_tok(4, 3, 7, 0, 0);
        exp_tok(0, 0, 0, 0, 1);
    endtask

    task automatic load_p4();
        clear_blk();
        blk[1] = -2048; blk[2] = 2047; blk[3] = -1;
        exp_tok(0, 0, 0, 1, 0);
        exp_tok(0, 11, 0, 0, 0);
        exp_tok(0, 11, 2047, 0, 0);
        exp_tok(0, 1, 0, 0, 0);
        exp_tok(0, 0, 0, 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_assert    = 0;
        n_fail      = 0;
        stall_en    = 1'b0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_coef     = '0;
        blk_restart = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_assert++;
        assert (in_ready === 1'b0 && out_valid === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_hold: got in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        assert (in_ready === 1'b1 && out_valid === 1'b0 && cur_tok === '0 && dbg_state === 2'd0) else begin
            n_fail++;
            $error("FAIL reset_out: got in_ready=%b out_valid=%b tok=%h state=%0d, required 1/0/0/0",
                   in_ready, out_valid, cur_tok, dbg_state);
        end
        @(posedge clk);
        #1;

        // DC=5, all AC zero; EOB one cycle after idx 63
        clear_blk();
        blk[0] = 5;
        exp_tok(0, 3, 5, 1, 0);
        exp_tok(0, 0, 0, 0, 1);
        for (int i = 0; i < 64; i++) begin
            blk_restart = (i == 0);
            send(blk[i]);
        end
        n_assert++;
        assert (out_valid === 1'b1 && cur_tok === tok(0, 0, 0, 0, 1)) else begin
            n_fail++;
            $error("FAIL eob_latency: got valid=%b tok=%h, required 1/%h", out_valid, cur_tok, tok(0, 0, 0, 0, 1));
        end
        drain();

        // Long trailing run ending in a nonzero idx 63
        load_p2(); send_block(1'b1); drain();
        // Single ZRL, then trailing zeros give EOB only
        load_p3(); send_block(1'b1); drain();
        // Saturation and size-11 extremes
        load_p4(); send_block(1'b1); drain();

        // Negative DC; three ZRLs mid-block; short-run value as the last token
        clear_blk();
        blk[0] = -7; blk[61] = 3; blk[63] = -2;
        exp_tok(0, 3, 0, 1, 0);
        exp_tok(15, 0, 0, 0, 0); exp_tok(15, 0, 0, 0, 0); exp_tok(15, 0, 0, 0, 0);
        exp_tok(12, 2, 3, 0, 0);
        exp_tok(1, 2, 1, 0, 1);
        send_block(1'b1); drain();

        // Run of exactly 15 (no ZRL) against exactly 16 (one ZRL)
        clear_blk();
        blk[16] = 2; blk[33] = 1;
        exp_tok(0, 0, 0, 1, 0);
        exp_tok(15, 2, 2, 0, 0);
        exp_tok(15, 0, 0, 0, 0);
        exp_tok(0, 1, 1, 0, 0);
        exp_tok(0, 0, 0, 0, 1);
        send_block(1'b1); drain();

        // Three-block stream with random downstream stalls
        stall_en = 1'b1;
        load_p2(); send_block(1'b1);
        load_p3(); send_block(1'b1);
        load_p4(); send_block(1'b1);
        drain();
        stall_en = 1'b0;
        @(posedge clk);
        #1;

        // DC predictor: lone restart pulse, then DCs 100, 90, restart with 40
        blk_restart = 1'b1;
        @(posedge clk);
        #1;
        blk_restart = 1'b0;
        clear_blk(); blk[0] = 100;
        exp_tok(0, 7, 100, 1, 0); exp_tok(0, 0, 0, 0, 1);
        send_block(1'b0);
        clear_blk(); blk[0] = 90;
`ifdef JPEG_RLE_DC_DIFF_EN
        exp_tok(0, 4, 5, 1, 0);
`else
        exp_tok(0, 7, 90, 1, 0);
`endif
        exp_tok(0, 0, 0, 0, 1);
        send_block(1'b0);
        clear_blk(); blk[0] = 40;
        exp_tok(0, 6, 40, 1, 0); exp_tok(0, 0, 0, 0, 1);
        send_block(1'b1);
        drain();

        // Reset at idx 30; the token from idx 29 is in flight and dropped
        blk_restart = 1'b1;
        send(3);
        exp_tok(0, 2, 3, 1, 0);
        for (int i = 1; i < 30; i++) begin
            if (i < 29) exp_tok(0, 1, 1, 0, 0);
            send(1);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_coef  = 12'sd9;
        @(negedge clk);
        n_assert++;
        assert (in_ready === 1'b0) else begin
            n_fail++;
            $error("FAIL midrst_ready: got %b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_assert++;
        assert (out_valid === 1'b0 && dbg_state === 2'd0) else begin
            n_fail++;
            $error("FAIL midrst_out: got valid=%b state=%0d, required 0/0", out_valid, dbg_state);
        end
        clear_blk(); blk[0] = 9;
        exp_tok(0, 4, 9, 1, 0); exp_tok(0, 0, 0, 0, 1);
        send_block(1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
